// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed 7-segment driver.
//   state_t : scan FSM states (IDLE, SHOW, GUARD)
//   GLYPH   : active-high glyph table indexed by nibble, bit order {g,f,e,d,c,b,a}
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg7_mux_driver_if.sv
// seg7_mux_driver_if: host/display bundle for seg7_mux_driver.
//   en, load, din, dp_in, blank_in : host -> driver (display data and control)
//   seg, dp, an, frame_start       : driver -> pins / host
// master = host side, slave = driver side.
interface seg7_mux_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
) ();

    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   din;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;

    modport master (
        output en, load, din, dp_in, blank_in,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  en, load, din, dp_in, blank_in,
        output seg, dp, an, frame_start
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-high segment decode.
//   nib   : hex value 0..F
//   seg_c : segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    always_comb seg_c = GLYPH[nib];

endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed 7-segment display driver with tear-free
// double buffering (pending -> shadow at frame start) and guard gaps between digits.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : seg7_mux_driver_if.slave (en/load/din/dp_in/blank_in in,
//              seg/dp/an/frame_start out, all outputs registered)
// Optional: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned GUARD_CYCLES   = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seg7_mux_driver_if.slave bus
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_t                state;
    logic [IW-1:0]         idx;
    logic [PW-1:0]         presc;
    logic [GW-1:0]         gcnt;
    logic [DW-1:0]         pend_din,   shad_din;
    logic [NUM_DIGITS-1:0] pend_dp,    shad_dp;
    logic [NUM_DIGITS-1:0] pend_blank, shad_blank;

    logic                  commit_c;
    logic [DW-1:0]         cur_din_c;
    logic [NUM_DIGITS-1:0] cur_dp_c;
    logic [NUM_DIGITS-1:0] cur_blank_c;
    logic [NUM_DIGITS-1:0] dark_c;
    logic [NUM_DIGITS-1:0] an_hi_c;
    logic [3:0]            nib_c;
    logic                  dp_sel_c;
    logic                  dark_sel_c;
    logic [6:0]            glyph_c;

    // First SHOW cycle of digit 0: the frame boundary where pending becomes shadow.
    // A load in this same cycle bypasses pending so the new frame already uses it.
    always_comb begin
        commit_c    = (state == SHOW) && (idx == '0) && (presc == '0);
        cur_din_c   = shad_din;
        cur_dp_c    = shad_dp;
        cur_blank_c = shad_blank;
        if (commit_c) begin
            cur_din_c   = bus.load ? bus.din      : pend_din;
            cur_dp_c    = bus.load ? bus.dp_in    : pend_dp;
            cur_blank_c = bus.load ? bus.blank_in : pend_blank;
        end
    end

`ifdef SEG7_LZB_EN
    logic lead_c;

    // Blank zeros from the top digit down; a non-zero digit or a lit dp ends it.
    always_comb begin
        dark_c = cur_blank_c;
        lead_c = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            if (lead_c && (cur_din_c[k*4 +: 4] == 4'h0) && !cur_dp_c[k]) begin
                dark_c[k] = 1'b1;
            end else begin
                lead_c = 1'b0;
            end
        end
    end
`else
    always_comb dark_c = cur_blank_c;
`endif

    // Select the active digit's data and build the active-high anode vector.
    always_comb begin
        nib_c      = 4'h0;
        dp_sel_c   = 1'b0;
        dark_sel_c = 1'b1;
        an_hi_c    = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx) begin
                nib_c      = cur_din_c[k*4 +: 4];
                dp_sel_c   = cur_dp_c[k];
                dark_sel_c = dark_c[k];
                an_hi_c[k] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nib   (nib_c),
        .seg_c (glyph_c)
    );

    // Scan FSM, data buffers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            presc           <= '0;
            gcnt            <= '0;
            pend_din        <= '0;
            pend_dp         <= '0;
            pend_blank      <= '1;
            shad_din        <= '0;
            shad_dp         <= '0;
            shad_blank      <= '1;
            bus.seg         <= SEG_OFF;
            bus.dp          <= DP_OFF;
            bus.an          <= AN_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_din   <= bus.din;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
            end
            shad_din   <= cur_din_c;
            shad_dp    <= cur_dp_c;
            shad_blank <= cur_blank_c;

            // en is also gated here so the pins go dark on the edge that sees en=0.
            if (bus.en && (state == SHOW)) begin
                bus.an          <= AN_ACTIVE_LOW ? ~an_hi_c : an_hi_c;
                bus.seg         <= dark_sel_c ? SEG_OFF
                                 : (SEG_ACTIVE_LOW ? ~glyph_c : glyph_c);
                bus.dp          <= dark_sel_c ? DP_OFF : (SEG_ACTIVE_LOW ? ~dp_sel_c : dp_sel_c);
                bus.frame_start <= commit_c;
            end else begin
                bus.an          <= AN_OFF;
                bus.seg         <= SEG_OFF;
                bus.dp          <= DP_OFF;
                bus.frame_start <= 1'b0;
            end

            if (!bus.en) begin
                state <= IDLE;
                idx   <= '0;
                presc <= '0;
                gcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SHOW;
                        idx   <= '0;
                        presc <= '0;
                        gcnt  <= '0;
                    end
                    SHOW: begin
                        if (presc == PW'(PRESCALE - 1)) begin
                            state <= GUARD;
                            presc <= '0;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    GUARD: begin
                        if (gcnt == GW'(GUARD_CYCLES - 1)) begin
                            state <= SHOW;
                            gcnt  <= '0;
                            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: scoreboard bench for seg7_mux_driver (4 digits,
// PRESCALE=4, GUARD_CYCLES=1, active-low pins). Expected pin vectors are
// queued per scenario and compared every falling edge.
// Honours SEG7_LZB_EN when building expected frames.
module tb_seg7_mux_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } vec_t;

    localparam vec_t OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

    // Standard hex glyphs, active high {g,f,e,d,c,b,a}.
    localparam logic [6:0] REF_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic  clk = 1'b0;
    logic  rst;
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "init";
    vec_t  sb[$];

    seg7_mux_driver_if #(.NUM_DIGITS(4)) bus ();

    seg7_mux_driver #(
        .NUM_DIGITS     (4),
        .PRESCALE       (4),
        .GUARD_CYCLES   (1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input vec_t got, input vec_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got an=%b seg=%h dp=%b fs=%b, expected an=%b seg=%h dp=%b fs=%b",
                     tag, $time, got.an, got.seg, got.dp, got.fs,
                     exp.an, exp.seg, exp.dp, exp.fs);
        end
    endtask

    // Queue the first n cycles of a frame showing d/p with blank mask bl.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                              input logic [3:0] bl, input int n);
        logic [3:0] dark;
        logic       lead;
        vec_t       v;
        int         cnt;
        dark = bl;
`ifdef SEG7_LZB_EN
        lead = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            if (lead && d[k*4 +: 4] == 4'h0 && !p[k]) dark[k] = 1'b1;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 4) begin
                    v = OFF;
                end else begin
                    v.an  = ~(4'b0001 << k);
                    v.seg = dark[k] ? 7'h7F : ~REF_GLYPH[d[k*4 +: 4]];
                    v.dp  = dark[k] ? 1'b1 : ~p[k];
                    v.fs  = (k == 0) && (c == 0);
                end
                if (cnt < n) sb.push_back(v);
                cnt++;
            end
        end
    endtask

    task automatic push_off(input int n);
        for (int i = 0; i < n; i++) sb.push_back(OFF);
    endtask

    // Advance n cycles, comparing the pins against the queue each falling edge.
    task automatic run(input int n);
        vec_t got;
        vec_t exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got = '{an: bus.an, seg: bus.seg, dp: bus.dp, fs: bus.frame_start};
            exp = (sb.size() > 0) ? sb.pop_front() : vec_t'('x);
            check_vec(phase, got, exp);
        end
    endtask

    // Single-cycle load strobe at a falling edge, then n-1 further cycles.
    task automatic load_run(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] bl, input int n);
        bus.din      = d;
        bus.dp_in    = p;
        bus.blank_in = bl;
        bus.load     = 1'b1;
        run(1);
        bus.load     = 1'b0;
        run(n - 1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.din      = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;

        phase = "reset";
        push_off(2);
        run(2);
        rst = 1'b0;
        phase = "idle";
        push_off(2);
        run(1);
        load_run(16'h3A1F, 4'h0, 4'h0, 1);

        phase = "scan";
        bus.en = 1'b1;
        push_off(1);
        push_frame(16'h3A1F, 4'h0, 4'h0, 20);
        push_frame(16'h3A1F, 4'h0, 4'h0, 20);
        run(41);

        phase = "tear_free";
        push_frame(16'h3A1F, 4'h0, 4'h0, 20);
        push_frame(16'h1234, 4'h0, 4'h0, 20);
        run(7);
        load_run(16'h1234, 4'h0, 4'h0, 33);

        phase = "load_at_frame_start";
        push_frame(16'hABCD, 4'h0, 4'h0, 20);
        load_run(16'hABCD, 4'h0, 4'h0, 20);

        phase = "two_loads";
        push_frame(16'hABCD, 4'h0, 4'h0, 20);
        push_frame(16'h0E5C, 4'h0, 4'h0, 20);
        run(3);
        load_run(16'h1111, 4'h0, 4'h0, 6);
        load_run(16'h0E5C, 4'h0, 4'h0, 31);

        phase = "blank_dp";
        push_frame(16'h0E5C, 4'h0, 4'h0, 20);
        push_frame(16'h0E5C, 4'b0001, 4'b0100, 20);
        run(5);
        load_run(16'h0E5C, 4'b0001, 4'b0100, 35);

        phase = "en_drop";
        push_frame(16'h0E5C, 4'b0001, 4'b0100, 7);
        run(7);
        bus.en = 1'b0;
        push_off(3);
        run(3);
        phase = "re_enable";
        bus.en = 1'b1;
        push_off(1);
        push_frame(16'h0E5C, 4'b0001, 4'b0100, 20);
        run(21);

        phase = "reset_mid_guard";
        push_frame(16'h0E5C, 4'b0001, 4'b0100, 4);
        run(4);
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.din      = 16'hFFFF;
        bus.dp_in    = 4'hF;
        bus.blank_in = 4'h0;
        push_off(2);
        run(2);
        rst      = 1'b0;
        bus.load = 1'b0;
        phase = "after_reset";
        push_off(1);
        push_frame(16'h0000, 4'h0, 4'hF, 20);
        run(21);

        phase = "hex_sweep";
        for (int v = 0; v < 16; v++) begin
            push_frame({12'h000, 4'(v)}, 4'h0, 4'h0, 20);
            load_run({12'h000, 4'(v)}, 4'h0, 4'h0, 20);
        end

        phase = "lzb_0050";
        push_frame(16'h0050, 4'h0, 4'h0, 20);
        load_run(16'h0050, 4'h0, 4'h0, 20);
        phase = "lzb_0000";
        push_frame(16'h0000, 4'h0, 4'h0, 20);
        load_run(16'h0000, 4'h0, 4'h0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
